// File: rtl/vend_credit_ctrl.sv
// Vending credit controller: accumulates coin credit in quarters, arbitrates
// cancel/select/coin, sequences dispense and pays change one quarter at a time.
module vend_credit_ctrl #(
  parameter int unsigned PRICE_Q      = 4,
  parameter int unsigned MAX_CREDIT_Q = 8,
  parameter int unsigned CW           = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    coin,
  input  logic          select,
  input  logic          cancel,
  input  logic          vend_done,
  input  logic          change_ack,
  output logic          vend_req,
  output logic          change_req,
  output logic          coin_reject,
  output logic [CW-1:0] credit,
  output logic          busy
);

  localparam int unsigned SW = CW + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [CW-1:0] credit_nx;
  logic          coin_reject_nx;
  logic          coin_accept;
  logic          coin_legal;
  logic [SW-1:0] coin_q;
  logic [SW-1:0] coin_sum;
  logic          coin_fits;

  // Coin decode: only a single one-hot bit in [3:0] is a legal coin.
  always_comb begin
    coin_q     = '0;
    coin_legal = 1'b0;
    case (coin)
      5'b00001: begin coin_q = SW'(1); coin_legal = 1'b1; end
      5'b00010: begin coin_q = SW'(2); coin_legal = 1'b1; end
      5'b00100: begin coin_q = SW'(3); coin_legal = 1'b1; end
      5'b01000: begin coin_q = SW'(4); coin_legal = 1'b1; end
      default:  begin coin_q = '0;     coin_legal = 1'b0; end
    endcase
  end

  // Sum is one bit wider than credit so the cap check cannot wrap.
  assign coin_sum  = SW'(credit) + coin_q;
  assign coin_fits = coin_legal && (coin_sum <= SW'(MAX_CREDIT_Q));

  always_comb begin
    state_nx    = state;
    credit_nx   = credit;
    coin_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (coin_fits) begin
          credit_nx   = CW'(coin_sum);
          state_nx    = S_CREDIT;
          coin_accept = 1'b1;
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          state_nx = S_CHANGE;
        end else if (select && (credit >= CW'(PRICE_Q))) begin
          credit_nx = credit - CW'(PRICE_Q);
          state_nx  = S_VEND;
        end else if (coin_fits) begin
          credit_nx   = CW'(coin_sum);
          coin_accept = 1'b1;
        end
      end
      S_VEND: begin
        if (vend_done) begin
          state_nx = (credit != '0) ? S_CHANGE : S_IDLE;
        end
      end
      S_CHANGE: begin
        // An empty register here can only come from corruption; leave cleanly.
        if (credit == '0) begin
          state_nx = S_IDLE;
        end else if (change_ack) begin
          credit_nx = credit - CW'(1);
          if (credit == CW'(1)) begin
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        state_nx  = S_IDLE;
        credit_nx = '0;
      end
    endcase
    coin_reject_nx = (coin != 5'b00000) && !coin_accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      coin_reject <= coin_reject_nx;
    end
  end

  assign vend_req   = (state == S_VEND);
  assign change_req = (state == S_CHANGE);
  assign busy       = (state == S_VEND) || (state == S_CHANGE);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Self-checking bench for vend_credit_ctrl: directed scenarios plus randomized
// traffic against a behavioural model of the vending rules.
module tb_vend_credit_ctrl;

  localparam int unsigned PRICE_Q      = 4;
  localparam int unsigned MAX_CREDIT_Q = 8;
  localparam int unsigned CW           = 4;

  localparam int M_IDLE   = 0;
  localparam int M_CREDIT = 1;
  localparam int M_VEND   = 2;
  localparam int M_CHANGE = 3;

  logic          clk;
  logic          reset;
  logic [4:0]    coin;
  logic          select;
  logic          cancel;
  logic          vend_done;
  logic          change_ack;
  logic          vend_req;
  logic          change_req;
  logic          coin_reject;
  logic [CW-1:0] credit;
  logic          busy;

  int n_tests;
  int n_fail;

  int m_state;
  int m_credit;
  bit m_rej;

  vend_credit_ctrl #(
    .PRICE_Q(PRICE_Q),
    .MAX_CREDIT_Q(MAX_CREDIT_Q),
    .CW(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin(coin),
    .select(select),
    .cancel(cancel),
    .vend_done(vend_done),
    .change_ack(change_ack),
    .vend_req(vend_req),
    .change_req(change_req),
    .coin_reject(coin_reject),
    .credit(credit),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int coin_value(input logic [4:0] c);
    if (c == 5'd1) return 1;
    if (c == 5'd2) return 2;
    if (c == 5'd4) return 3;
    if (c == 5'd8) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_state  = M_IDLE;
    m_credit = 0;
    m_rej    = 1'b0;
  endtask

  // Behavioural rules applied once per clock edge.
  task automatic model_step(input logic [4:0] c, input logic s, input logic cn,
                            input logic vd, input logic ak);
    int q;
    bit took;
    q    = coin_value(c);
    took = 1'b0;
    if (m_state == M_IDLE) begin
      if (q > 0 && q <= int'(MAX_CREDIT_Q)) begin
        m_credit = q;
        m_state  = M_CREDIT;
        took     = 1'b1;
      end
    end else if (m_state == M_CREDIT) begin
      if (cn) m_state = M_CHANGE;
      else if (s && m_credit >= int'(PRICE_Q)) begin
        m_credit = m_credit - int'(PRICE_Q);
        m_state  = M_VEND;
      end else if (q > 0 && m_credit + q <= int'(MAX_CREDIT_Q)) begin
        m_credit = m_credit + q;
        took     = 1'b1;
      end
    end else if (m_state == M_VEND) begin
      if (vd) m_state = (m_credit > 0) ? M_CHANGE : M_IDLE;
    end else begin
      if (ak) begin
        m_credit = m_credit - 1;
        if (m_credit == 0) m_state = M_IDLE;
      end
    end
    m_rej = (c != 5'd0) && !took;
  endtask

  task automatic drive(input logic [4:0] c, input logic s, input logic cn,
                       input logic vd, input logic ak);
    coin = c; select = s; cancel = cn; vend_done = vd; change_ack = ak;
    @(posedge clk);
    model_step(c, s, cn, vd, ak);
    #1;
    coin = 5'd0; select = 1'b0; cancel = 1'b0; vend_done = 1'b0; change_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (credit !== 4'd0) begin n_fail++; $display("FAIL reset_credit: got %0d want 0", credit); end
    n_tests++;
    if ({vend_req, change_req, busy, coin_reject} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got vreq/creq/busy/rej=%b want 0000",
               {vend_req, change_req, busy, coin_reject});
    end
  endtask

  task automatic test_basic_vend();
    int exp_c [3] = '{1, 2, 4};
    logic [4:0] seq [3] = '{5'b00001, 5'b00001, 5'b00010};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i], 1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (credit !== 4'(exp_c[i])) begin
        n_fail++; $display("FAIL basic_credit%0d: got %0d want %0d", i, credit, exp_c[i]);
      end
    end
    drive(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (credit !== 4'd0 || vend_req !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_vend: got credit=%0d vreq=%b busy=%b want 0 1 1", credit, vend_req, busy);
    end
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 1'b0, 1'b0, (i == 2), 1'b0);
      n_tests++;
      if (change_req !== 1'b0) begin
        n_fail++; $display("FAIL basic_no_change%0d: got change_req=%b want 0", i, change_req);
      end
    end
    n_tests++;
    if (vend_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: got vreq=%b busy=%b want 0 0", vend_req, busy);
    end
  endtask

  task automatic test_change();
    drive(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (credit !== 4'd7) begin n_fail++; $display("FAIL change_load: got %0d want 7", credit); end
    drive(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (credit !== 4'd3 || vend_req !== 1'b1) begin
      n_fail++; $display("FAIL change_vend: got credit=%0d vreq=%b want 3 1", credit, vend_req);
    end
    drive(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (change_req !== 1'b1 || vend_req !== 1'b0) begin
      n_fail++; $display("FAIL change_enter: got creq=%b vreq=%b want 1 0", change_req, vend_req);
    end
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (credit !== 4'(2 - i)) begin
        n_fail++; $display("FAIL change_ack%0d: got %0d want %0d", i, credit, 2 - i);
      end
      if (i < 2) drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (change_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL change_done: got creq=%b busy=%b want 0 0", change_req, busy);
    end
  endtask

  task automatic test_cap();
    drive(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'b00010, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 4'd7) begin
      n_fail++; $display("FAIL cap_reject: got rej=%b credit=%0d want 1 7", coin_reject, credit);
    end
    drive(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (coin_reject !== 1'b0 || credit !== 4'd8) begin
      n_fail++; $display("FAIL cap_fill: got rej=%b credit=%0d want 0 8", coin_reject, credit);
    end
    drive(5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 4'd8) begin
      n_fail++; $display("FAIL cap_multihot: got rej=%b credit=%0d want 1 8", coin_reject, credit);
    end
    drive(5'b10000, 1'b0, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (coin_reject !== 1'b1 || change_req !== 1'b1) begin
      n_fail++; $display("FAIL cap_bit4: got rej=%b creq=%b want 1 1", coin_reject, change_req);
    end
    for (int i = 0; i < 8; i++) drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (credit !== 4'd0 || busy !== 1'b0 || coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL cap_drain: got credit=%0d busy=%b rej=%b want 0 0 0", credit, busy, coin_reject);
    end
  endtask

  task automatic test_select_low();
    drive(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (credit !== 4'd3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL low_select: got credit=%0d busy=%b want 3 0", credit, busy);
    end
    drive(5'b00001, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (change_req !== 1'b1 || credit !== 4'd3 || coin_reject !== 1'b1) begin
      n_fail++; $display("FAIL low_cancel: got creq=%b credit=%0d rej=%b want 1 3 1",
                         change_req, credit, coin_reject);
    end
    for (int i = 0; i < 3; i++) drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (credit !== 4'd0 || change_req !== 1'b0) begin
      n_fail++; $display("FAIL low_drain: got credit=%0d creq=%b want 0 0", credit, change_req);
    end
  endtask

  task automatic test_vend_ignore();
    drive(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(5'b01000, 1'b1, 1'b1, 1'b0, 1'b0);
    n_tests++;
    if (coin_reject !== 1'b1 || credit !== 4'd0 || vend_req !== 1'b1) begin
      n_fail++; $display("FAIL vend_ignore: got rej=%b credit=%0d vreq=%b want 1 0 1",
                         coin_reject, credit, vend_req);
    end
    drive(5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(5'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (credit !== 4'd0 || busy !== 1'b0 || change_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_stray: got credit=%0d busy=%b creq=%b want 0 0 0", credit, busy, change_req);
    end
  endtask

  task automatic test_reset_mid_change();
    drive(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (credit !== 4'd2 || change_req !== 1'b1) begin
      n_fail++; $display("FAIL rmc_setup: got credit=%0d creq=%b want 2 1", credit, change_req);
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (credit !== 4'd0 || change_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmc_async: got credit=%0d creq=%b busy=%b want 0 0 0", credit, change_req, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (credit !== 4'd1 || coin_reject !== 1'b0) begin
      n_fail++; $display("FAIL rmc_after: got credit=%0d rej=%b want 1 0", credit, coin_reject);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [4:0] bad [4] = '{5'b00011, 5'b10000, 5'b00101, 5'b11111};
    logic [4:0] good [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};
    logic [4:0] c;
    int r;
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) c = 5'd0;
      else if (r < 9) c = good[r - 5];
      else c = bad[$urandom_range(0, 3)];
      drive(c, ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
      n_tests++;
      if (credit !== 4'(m_credit) || coin_reject !== m_rej ||
          vend_req !== (m_state == M_VEND) || change_req !== (m_state == M_CHANGE) ||
          busy !== (m_state == M_VEND || m_state == M_CHANGE)) begin
        n_fail++;
        $display("FAIL random%0d: got credit=%0d rej=%b vreq=%b creq=%b busy=%b want credit=%0d rej=%b state=%0d",
                 i, credit, coin_reject, vend_req, change_req, busy, m_credit, m_rej, m_state);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    coin = 5'd0; select = 1'b0; cancel = 1'b0; vend_done = 1'b0; change_ack = 1'b0;
    model_reset();
    test_reset();
    test_basic_vend();
    test_change();
    test_cap();
    test_select_low();
    test_vend_ignore();
    test_reset_mid_change();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
